// File: rtl/vga_scan_out.sv
// vga_scan_out: VGA timing generator that scans a 256x256 image window out of a dual-buffer video memory.
// Buffer selection latches at the first blanking line so a displayed frame never tears.
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int IMG_X0 = 192,
  parameter int IMG_Y0 = 112,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        buf_sel,
  output logic [16:0] raddr,
  input  logic [11:0] rdata,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        buf_shown,
  output logic        frame_start
);
  localparam logic [9:0] H_END = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_END = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] HS_B = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_B = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X0 = 10'(IMG_X0);
  localparam logic [9:0] X1 = 10'(IMG_X0 + IMG_W);
  localparam logic [9:0] Y0 = 10'(IMG_Y0);
  localparam logic [9:0] Y1 = 10'(IMG_Y0 + IMG_H);
  logic [9:0] h, v;
  logic [7:0] dx, dy;
  logic active, in_img, hs0, vs0;
  logic act1, img1, hs1, vs1;
  logic [11:0] rgb;
  assign active = h < HA && v < VA;
  assign in_img = active && h >= X0 && h < X1 && v >= Y0 && v < Y1;
  assign hs0 = !(h >= HS_B && h < HS_E);
  assign vs0 = !(v >= VS_B && v < VS_E);
  assign dx = h[7:0] - X0[7:0];
  assign dy = v[7:0] - Y0[7:0];
  assign raddr = in_img ? {buf_shown, dy, dx} : {buf_shown, 16'h0000};
  assign {vga_r, vga_g, vga_b} = rgb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
      buf_shown <= 1'b0;
      frame_start <= 1'b0;
      act1 <= 1'b0;
      img1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      rgb <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      h <= h == H_END ? '0 : h + 10'd1;
      v <= h == H_END ? (v == V_END ? '0 : v + 10'd1) : v;
      frame_start <= h == '0 && v == '0;
      // sample point: start of the first blanking line
      if (h == '0 && v == VA) buf_shown <= buf_sel;
      act1 <= active;
      img1 <= in_img;
      hs1 <= hs0;
      vs1 <= vs0;
      rgb <= img1 ? rdata : (act1 ? BORDER_RGB : 12'h000);
      vga_hs <= hs1;
      vga_vs <= vs1;
    end
  end
endmodule

// File: doc/vga_scan_out.md
# vga_scan_out

Display-side consumer of the dual-image video memory. Generates 640x480@60 VGA timing from a 25 MHz pixel clock and issues one read address per active pixel into the 17-bit read port. Places the selected 256x256 image at a fixed window and drives the 4:4:4 RGB pins. Buffer selection is frame-synchronous so the image shown never tears while the coprocessor writes the other buffer.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync, in lines
- IMG_X0 / IMG_Y0, 192 / 112, top-left corner of the 256x256 image window
- BORDER_RGB, 12'h000, colour of active pixels outside the window

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst_n  in  1  asynchronous active-low reset
- buf_sel  in  1  requested image buffer (0: addresses 0..65535, 1: 65536..131071)
- raddr  out  17  video memory read address
- rdata  in  12  video memory read data, valid one cycle after raddr
- vga_r / vga_g / vga_b  out  4 each  pixel colour ({r,g,b} = rdata[11:8], [7:4], [3:0])
- vga_hs / vga_vs  out  1 each  sync outputs, active low
- buf_shown  out  1  buffer currently being scanned
- frame_start  out  1  one-cycle pulse at counter position (h=0, v=0)

## Operation
- Counters:
  - h counts 0..799 (sum of H parameters minus 1), then wraps to 0 and v increments.
  - v counts 0..524 and wraps to 0 at the end of line 524.
- Stage 0 (counter cycle t):
  - active = h < 640 && v < 480.
  - in_img = active && IMG_X0 <= h < IMG_X0+256 && IMG_Y0 <= v < IMG_Y0+256.
  - hs0 = !(656 <= h < 752).
  - vs0 = !(490 <= v < 492).
- raddr, combinational from stage 0:
  - in_img: {buf_shown, (v-IMG_Y0)[7:0], (h-IMG_X0)[7:0]}.
  - Otherwise: {buf_shown, 16'h0000}.
- Stage 1 registers active, in_img, hs0 and vs0. rdata is valid in this stage.
- Stage 2 is the output register:
  - rgb = in_img ? rdata : (active ? BORDER_RGB : 12'h000).
  - vga_hs and vga_vs take the stage-1 sync values.
- Buffer swap:
  - buf_shown <= buf_sel only on the cycle where h=0 and v=V_ACTIVE (first blanking line).
  - buf_sel changes at any other time are ignored until that point.
  - buf_shown is constant across all active lines of a frame.
- frame_start is registered and asserts in the cycle after the counters reach (0,0). It is not delayed through the pixel pipe.
- No stall or back-pressure. The memory read port has a fixed 1-cycle latency.

## Timing
- Reset values:
  - h=0, v=0, buf_shown=0, frame_start=0.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1.
  - raddr={buf_shown,16'h0}=0.
  - All pipeline flags are 0 and sync flags are 1.
- Latency from counter position to pins is 2 cycles for colour, hs and vs alike, so sync and colour stay aligned.
- Line period is 800 clocks. Frame period is 420000 clocks.
- hsync low for 96 clocks. vsync low for 2 full lines (1600 clocks).
- Wrap: (799,524) -> (0,0) in one cycle; frame_start pulses in the next cycle.
- Reset asserted mid-frame:
  - All state clears immediately (asynchronous).
  - After release the scan restarts at (0,0) with buf_shown=0, even if buf_sel=1, until the next v=480 sample.
- buf_sel toggling on the same cycle as the sample point (h=0, v=480): the value present on that edge is taken.

## Test plan
- Reset: hold rst_n=0 -> pins 0, hs=vs=1, raddr=0. After release, first frame_start occurs 1 cycle after reset release (counters already at 0,0), then every 420000 cycles.
- Sync timing:
  - vga_hs falls 658 cycles after the counter passes h=0 and stays low 96 cycles.
  - vga_vs is low for exactly 1600 cycles per frame.
  - Both repeat with periods 800 and 420000.
- Address/data path:
  - Memory model with mem[a]=a[11:0], buf_sel=0.
  - At (192,112) raddr=17'h00000; at (447,367) raddr=17'h0FFFF.
  - Colour pins equal the memory word exactly 2 cycles after each address.
- Border/blank:
  - BORDER_RGB=12'hF00.
  - Pixel (0,0) outputs F/0/0.
  - Pixel (191,112) outputs F/0/0.
  - Pixel (700,10), in blanking, outputs 0/0/0.
- Buffer swap:
  - Set buf_sel=1 at (300,200) -> raddr[16] stays 0 for the rest of that frame.
  - buf_shown becomes 1 at (0,480).
  - Next frame, first window address is 17'h10000.
- Reset mid-frame: assert rst_n low at (400,300) with buf_shown=1 -> immediate reset values. After release, raddr[16]=0 throughout the first frame.
